// File: rtl/td4_top.sv
// TD4-class 4-bit single-cycle CPU: 16x8 parameter ROM, switch input, registered LED output.
// Optional TD4_SW_SYNC_EN puts a two-flop synchronizer in front of the switch port.
module td4_top #(
    parameter logic [127:0] ROM_IMAGE = 128'h0000_0000_0000_0000_0000_0000_F190_5170
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] sw,
    output logic [3:0] LED
);

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_A  = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_B  = 4'b0111;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] out_q, out_d;
    logic [3:0] pc_q, pc_d;
    logic       c_q, c_d;

    logic [7:0] instr;
    logic [3:0] opcode;
    logic [3:0] im;
    logic [3:0] src;
    logic [4:0] sum;
    logic [3:0] sw_eff;

`ifdef TD4_SW_SYNC_EN
    logic [3:0] sw_meta_q;
    logic [3:0] sw_sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta_q <= 4'd0;
            sw_sync_q <= 4'd0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign sw_eff = sw_sync_q;
`else
    assign sw_eff = sw;
`endif

    assign instr  = ROM_IMAGE[{pc_q, 3'b000} +: 8];
    assign opcode = instr[7:4];
    assign im     = instr[3:0];

    always_comb begin
        src = 4'd0;
        case (opcode)
            OP_ADD_A, OP_MOV_BA:           src = a_q;
            OP_ADD_B, OP_MOV_AB, OP_OUT_B: src = b_q;
            OP_IN_A, OP_IN_B:              src = sw_eff;
            default:                       src = 4'd0;
        endcase
    end

    assign sum = {1'b0, src} + {1'b0, im};

    // Jumps and undefined opcodes fall through with C cleared.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        out_d = out_q;
        pc_d  = pc_q + 4'd1;
        c_d   = 1'b0;
        case (opcode)
            OP_ADD_A, OP_MOV_A, OP_MOV_AB, OP_IN_A: begin
                a_d = sum[3:0];
                c_d = sum[4];
            end
            OP_ADD_B, OP_MOV_B, OP_MOV_BA, OP_IN_B: begin
                b_d = sum[3:0];
                c_d = sum[4];
            end
            OP_OUT_B, OP_OUT_I: begin
                out_d = sum[3:0];
                c_d   = sum[4];
            end
            OP_JMP: pc_d = im;
            OP_JNC: begin
                if (!c_q) pc_d = im;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q   <= 4'd0;
            b_q   <= 4'd0;
            out_q <= 4'd0;
            pc_q  <= 4'd0;
            c_q   <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            out_q <= out_d;
            pc_q  <= pc_d;
            c_q   <= c_d;
        end
    end

    assign LED = out_q;

endmodule

// File: tb/tb_td4_top.sv
// Bench for td4_top: several instances with different ROM images, driven one after another.
module tb_td4_top;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_def = 1'b0;
    logic rst_in  = 1'b1;
    logic rst_j1  = 1'b1;
    logic rst_j2  = 1'b1;
    logic rst_nop = 1'b1;
    logic rst_sy  = 1'b1;

    logic [3:0] sw_zero = 4'd0;
    logic [3:0] sw_in   = 4'b0101;
    logic [3:0] sw_sy   = 4'b0011;

    logic [3:0] led_def, led_in, led_j1, led_j2, led_nop, led_sy;

    td4_top dut_def (.clock(clock), .reset(rst_def), .sw(sw_zero), .LED(led_def));

    td4_top #(.ROM_IMAGE(128'h0000_0000_0000_0000_0000_0000_0090_4320))
        dut_in (.clock(clock), .reset(rst_in), .sw(sw_in), .LED(led_in));

    td4_top #(.ROM_IMAGE(128'h0000_0000_0000_0000_0000_00F3_B7E0_013E))
        dut_j1 (.clock(clock), .reset(rst_j1), .sw(sw_zero), .LED(led_j1));

    td4_top #(.ROM_IMAGE(128'h0000_0000_0000_0000_0000_00F3_B7E0_023E))
        dut_j2 (.clock(clock), .reset(rst_j2), .sw(sw_zero), .LED(led_j2));

    td4_top #(.ROM_IMAGE(128'h0000_0000_0000_00F8_B9F6_B5E7_8F01_0F8F))
        dut_nop (.clock(clock), .reset(rst_nop), .sw(sw_zero), .LED(led_nop));

    td4_top #(.ROM_IMAGE({16{8'h20}}))
        dut_sy (.clock(clock), .reset(rst_sy), .sw(sw_sy), .LED(led_sy));

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        logic [3:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int         edges;
        logic [3:0] led;
    } vec_t;
    vec_t tbl[6];

    task automatic push(input string nm, input logic [3:0] e);
        sb_t s;
        s.nm  = nm;
        s.exp = e;
        sb_q.push_back(s);
    endtask

    task automatic chk(input logic [3:0] act);
        sb_t s;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d with nothing expected", act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", s.nm, act, s.exp);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        tbl[0] = '{3, 4'd1};
        tbl[1] = '{1, 4'd1};
        tbl[2] = '{2, 4'd2};
        tbl[3] = '{3, 4'd3};
        tbl[4] = '{3, 4'd4};
        tbl[5] = '{3, 4'd5};

        // Default program: reset, count up, async reset mid-run, count through the wrap.
        #1 rst_def = 1'b1;
        push("reset_led", 4'd0);
        #1 chk(led_def);
        @(negedge clock) rst_def = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push($sformatf("default_run[%0d]", i), tbl[i].led);
            tick(tbl[i].edges);
            chk(led_def);
        end
        rst_def = 1'b1;
        push("midrun_reset", 4'd0);
        #1 chk(led_def);
        @(negedge clock) rst_def = 1'b0;
        push("restart_led", 4'd1);
        tick(3);
        chk(led_def);
        for (int k = 2; k <= 16; k++) begin
            push($sformatf("count_%0d", k), 4'(k));
            tick(3);
            chk(led_def);
        end

        // IN A; MOV B,A+3; OUT B with sw=0101.
        @(negedge clock) rst_in = 1'b0;
        push("in_before_out", 4'd0);
        tick(2);
        chk(led_in);
`ifdef TD4_SW_SYNC_EN
        push("in_mov_out", 4'd3);
`else
        push("in_mov_out", 4'd8);
`endif
        tick(1);
        chk(led_in);

        // JNC taken when the preceding ADD produced no carry.
        @(negedge clock) rst_j1 = 1'b0;
        push("j1_a_after_add", 4'd15);
        tick(2);
        chk(dut_j1.a_q);
        push("j1_pc_after_jnc", 4'd0);
        tick(1);
        chk(dut_j1.pc_q);
        push("j1_led_never_out", 4'd0);
        tick(6);
        chk(led_j1);

        // JNC falls through when the ADD carried out.
        @(negedge clock) rst_j2 = 1'b0;
        push("j2_a_wrap", 4'd0);
        push("j2_carry", 4'd1);
        tick(2);
        chk(dut_j2.a_q);
        chk({3'b000, dut_j2.c_q});
        push("j2_pc_fallthrough", 4'd3);
        tick(1);
        chk(dut_j2.pc_q);
        push("j2_led_out7", 4'd7);
        tick(1);
        chk(led_j2);

        // Undefined opcode: no register write, PC advances, C cleared.
        @(negedge clock) rst_nop = 1'b0;
        push("nop_pc", 4'd1);
        push("nop_a", 4'd0);
        push("nop_b", 4'd0);
        push("nop_led", 4'd0);
        tick(1);
        chk(dut_nop.pc_q);
        chk(dut_nop.a_q);
        chk(dut_nop.b_q);
        chk(led_nop);
        push("nop_pre_carry", 4'd1);
        tick(2);
        chk({3'b000, dut_nop.c_q});
        push("nop_clears_c", 4'd0);
        push("nop_pc4", 4'd4);
        push("nop_a_kept", 4'd0);
        tick(1);
        chk({3'b000, dut_nop.c_q});
        chk(dut_nop.pc_q);
        chk(dut_nop.a_q);
        push("nop_jnc_taken_led", 4'd9);
        tick(2);
        chk(led_nop);

        // Switch change seen by a stream of IN A instructions.
        @(negedge clock) rst_sy = 1'b0;
        push("sy_settled", 4'd3);
        tick(4);
        chk(dut_sy.a_q);
        sw_sy = 4'b1100;
`ifdef TD4_SW_SYNC_EN
        push("sy_first_in", 4'd3);
`else
        push("sy_first_in", 4'd12);
`endif
        tick(1);
        chk(dut_sy.a_q);
        push("sy_third_in", 4'd12);
        tick(2);
        chk(dut_sy.a_q);

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/td4_top.md
Name: td4_top

Overview:
- Top level of a TD4-class 4-bit single-cycle CPU with an internal 16x8 instruction ROM, a 4-bit switch input port and a 4-bit registered LED output port.
- Each rising clock edge fetches, decodes and executes one instruction.
- This is the FPGA board top: the switches feed IN instructions and the LEDs show the OUT register.

Parameters:
- ROM_IMAGE, default 128'h0000_0000_0000_0000_0000_0000_F190_5170, program ROM contents. The byte at address i is ROM_IMAGE[8i+7:8i]. The default program is: 0:MOV B,0; 1:ADD B,1; 2:OUT B; 3:JMP 1; all other bytes 0x00.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- sw  input  4  switch input port, read by IN instructions.
- LED  output  4  output port; driven directly by the OUT register.

Behaviour:
- State: A[3:0], B[3:0], OUT[3:0], PC[3:0], C (carry flag).
- Reset: reset=1 asynchronously clears A, B, OUT, PC and C to 0, so LED=0. The CPU runs from the first rising edge after reset=0. Reset asserted mid-program aborts immediately; execution restarts at PC=0.
- Fetch: instr = ROM[PC], opcode = instr[7:4], im = instr[3:0]. The ROM is combinational; there are no wait states.
- ALU: sum[4:0] = src + im, an unsigned 5-bit sum. Every defined instruction loads C <= sum[4].
- src select per opcode:
  - A: ADD A, MOV B,A
  - B: ADD B, MOV A,B, OUT B
  - sw: IN A, IN B
  - 0: all other opcodes
- Destination write of sum[3:0] per opcode:
  - 0000 ADD A,Im -> A
  - 0101 ADD B,Im -> B
  - 0011 MOV A,Im -> A
  - 0111 MOV B,Im -> B
  - 0001 MOV A,B -> A (im added)
  - 0100 MOV B,A -> B (im added)
  - 0010 IN A -> A
  - 0110 IN B -> B
  - 1001 OUT B -> OUT
  - 1011 OUT Im -> OUT
- Jumps:
  - 1111 JMP Im: PC <= im.
  - 1110 JNC Im: PC <= im if C==0 (C from the previous instruction), else PC+1.
  - Both jumps write C <= 0.
- All other instructions: PC <= PC+1, wrapping from 15 to 0.
- Undefined opcodes (1000, 1010, 1100, 1101): NOP. No register write, PC+1, C <= 0.
- Register wrap: 4-bit results wrap modulo 16. For example, ADD A,1 with A=15 gives A=0 and C=1.
- sw is sampled at the executing edge with no latching; it is asynchronous to the CPU unless the optional feature is enabled.
- LED changes only on the edge that executes an OUT instruction.
- Latency: one instruction per clock; results are visible immediately after that edge.

Optional Feature:
- Macro: TD4_SW_SYNC_EN.
- Defined: sw passes through a two-flop synchronizer clocked by clock and cleared by reset. IN instructions read the synchronized value, so a switch change is visible to IN two edges later.
- Undefined: IN reads sw directly.

Test Plan:
- Reset with the default ROM: reset=1 -> LED=0 with no clock edge. Release and run 3 edges -> LED=1. Every 3 further edges LED increments (2, 3, ...). After LED=15 the next output is 0.
- Asynchronous reset mid-run: assert reset while LED=5, between edges -> LED=0 immediately. After release, the program restarts and LED=1 after 3 edges.
- Custom ROM, bytes in address order 0x2? (IN A), 0x43 (MOV B,A with im=3), 0x90 (OUT B), with sw=4'b0101 -> LED=8 after 3 edges.
- Carry/JNC, ROM 0x3E, 0x01, 0xE0, 0xB7, 0xF3:
  - Execution: MOV A,14; ADD A,1 gives 15 with C=0; JNC 0 taken; loop repeats.
  - Separate run with ADD A,2 (0x02) gives C=1: JNC falls through, OUT 7 executes, LED=7.
- Undefined opcode 0x8F at PC=0 -> PC=1, A, B and LED unchanged, C=0.
- With TD4_SW_SYNC_EN: change sw one edge before IN A -> A gets the old value; IN A two edges later gets the new value.
